// File: rtl/sobel_window_ctrl_pkg.sv
// Shared types and constants for the Sobel window controller and its core.
package sobel_window_ctrl_pkg;

  localparam int unsigned PIXEL_WIDTH_OUT = 8;
  localparam int unsigned MAX_PIXEL_VAL   = 256;

  // Indexed [row][col]; row 0 is the oldest line, col 0 the oldest column.
  typedef logic [2:0][2:0][PIXEL_WIDTH_OUT-1:0] sobel_matrix;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN
  } sobel_ctrl_state_t;

endpackage

// File: rtl/sobel_core.sv
// Combinational Sobel operator: |Gx| + |Gy| over a 3x3 window, clamped to MAX_PIXEL_VAL-1.
module sobel_core
  import sobel_window_ctrl_pkg::*;
(
  input  sobel_matrix                window_i,
  output logic [PIXEL_WIDTH_OUT-1:0] magnitude_o
);

  // Four extra bits cover the 4x kernel gain plus the sign.
  localparam int unsigned GradW = PIXEL_WIDTH_OUT + 4;

  logic signed [GradW-1:0] x_grad, y_grad;
  logic        [GradW-1:0] x_abs, y_abs, sum;

  function automatic logic signed [GradW-1:0] ext(input logic [PIXEL_WIDTH_OUT-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  always_comb begin
    x_grad = (ext(window_i[0][2]) + (ext(window_i[1][2]) <<< 1) + ext(window_i[2][2]))
           - (ext(window_i[0][0]) + (ext(window_i[1][0]) <<< 1) + ext(window_i[2][0]));
    y_grad = (ext(window_i[2][0]) + (ext(window_i[2][1]) <<< 1) + ext(window_i[2][2]))
           - (ext(window_i[0][0]) + (ext(window_i[0][1]) <<< 1) + ext(window_i[0][2]));
    x_abs  = x_grad[GradW-1] ? GradW'(-x_grad) : GradW'(x_grad);
    y_abs  = y_grad[GradW-1] ? GradW'(-y_grad) : GradW'(y_grad);
    sum    = x_abs + y_abs;
    if (sum > GradW'(MAX_PIXEL_VAL - 1)) begin
      magnitude_o = PIXEL_WIDTH_OUT'(MAX_PIXEL_VAL - 1);
    end else begin
      magnitude_o = sum[PIXEL_WIDTH_OUT-1:0];
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Streams a raster frame through two line buffers and a 3x3 window into sobel_core,
// emitting interior-pixel magnitudes on a valid/ready output with one-cycle latency.
module sobel_window_ctrl
  import sobel_window_ctrl_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned IMG_HEIGHT = 24
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       sof_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [PIXEL_WIDTH_OUT-1:0] in_pixel_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [PIXEL_WIDTH_OUT-1:0] out_pixel_o,
  output logic                       frame_done_o,
  output logic                       busy_o
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);

  sobel_ctrl_state_t state_q, state_d;
  logic [ColW-1:0] col_q, col_d, pos_col, nxt_col;
  logic [RowW-1:0] row_q, row_d, pos_row, nxt_row;
  logic out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  logic [PIXEL_WIDTH_OUT-1:0] out_pixel_q, out_pixel_d, core_mag;
  logic accept, take, emit, last_col, last_row;

  logic [PIXEL_WIDTH_OUT-1:0] lb1_q [IMG_WIDTH];
  logic [PIXEL_WIDTH_OUT-1:0] lb2_q [IMG_WIDTH];
  logic [2:0][PIXEL_WIDTH_OUT-1:0] vec_q [3];
  logic [PIXEL_WIDTH_OUT-1:0] new_col [3];
  sobel_matrix window;

  assign in_ready_o = (state_q != DRAIN) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  // An accepted sof is pixel (0,0) of a new frame from any state; other pixels only count in-frame.
  assign take       = accept && (sof_i || state_q == FILL || state_q == RUN);
  assign pos_col    = sof_i ? '0 : col_q;
  assign pos_row    = sof_i ? '0 : row_q;
  assign last_col   = (pos_col == ColW'(IMG_WIDTH - 1));
  assign last_row   = (pos_row == RowW'(IMG_HEIGHT - 1));
  assign emit       = take && (pos_row >= RowW'(2)) && (pos_col >= ColW'(2));

  always_comb begin
    nxt_col = pos_col + 1'b1;
    nxt_row = pos_row;
    if (last_col) begin
      nxt_col = '0;
      nxt_row = pos_row + 1'b1;
    end
  end

  // Core sees the window as it will be after this accept, so the result registers on the same edge.
  assign new_col[0] = lb2_q[pos_col];
  assign new_col[1] = lb1_q[pos_col];
  assign new_col[2] = in_pixel_i;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      window[r] = {new_col[r], vec_q[r][2], vec_q[r][1]};
    end
  end

  sobel_core u_sobel_core (
    .window_i    (window),
    .magnitude_o (core_mag)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE, FILL, RUN: begin
        if (take) begin
          if (last_col && last_row) begin
            state_d = DRAIN;
            col_d   = '0;
            row_d   = '0;
          end else begin
            col_d   = nxt_col;
            row_d   = nxt_row;
            state_d = (nxt_row >= RowW'(2) && nxt_col >= ColW'(2)) ? RUN : FILL;
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready_i) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_pixel_d = core_mag;
    end else if (take && sof_i) begin
      out_valid_d = 1'b0;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Data path needs no reset: FILL overwrites every entry before it is used.
  always_ff @(posedge clk_i) begin
    if (take) begin
      lb2_q[pos_col] <= lb1_q[pos_col];
      lb1_q[pos_col] <= in_pixel_i;
      for (int r = 0; r < 3; r++) begin
        vec_q[r] <= {new_col[r], vec_q[r][2], vec_q[r][1]};
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_pixel_o  = out_pixel_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench: expected magnitudes are queued at input accept and compared at output handshake.
module tb_sobel_window_ctrl;
  import sobel_window_ctrl_pkg::*;

  localparam int W = 8;
  localparam int H = 5;
  localparam int NOUT = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic reset_i, sof_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, frame_done_o, busy_o;
  logic [PIXEL_WIDTH_OUT-1:0] in_pixel_i, out_pixel_o;

  int img [H][W];
  int sb_q [$];
  int n_checks = 0;
  int n_pass = 0;
  int out_count = 0;
  int fd_count = 0;
  bit rand_ready = 1'b0;
  bit hold_ready = 1'b0;
  bit rand_gap = 1'b0;

  always #5 clk = ~clk;

  sobel_window_ctrl #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .sof_i        (sof_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_pixel_i   (in_pixel_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_pixel_o  (out_pixel_o),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Software Sobel at centre (r,c).
  function automatic int model(input int r, input int c);
    int gx, gy, m;
    gx = (img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2 * img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2 * img[r-1][c] + img[r-1][c+1]);
    m = iabs(gx) + iabs(gy);
    return (m > MAX_PIXEL_VAL - 1) ? MAX_PIXEL_VAL - 1 : m;
  endfunction

  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_ready) out_ready_i = 1'b0;
      else if (rand_ready) out_ready_i = 1'($urandom_range(0, 1));
      else out_ready_i = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_i) begin
        if (frame_done_o) fd_count++;
        if (out_valid_o && out_ready_i) begin
          check("sb_has_entry", int'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) check("out_pixel", int'(out_pixel_o), sb_q.pop_front());
          out_count++;
        end
        if (out_valid_o && !out_ready_i) check("bp_in_ready", int'(in_ready_o), 0);
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input int r, input int c, input logic sof, input bit track);
    bit accepted = 1'b0;
    in_valid_i = 1'b1;
    sof_i      = sof;
    in_pixel_i = PIXEL_WIDTH_OUT'(img[r][c]);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready_o) begin
        accepted = 1'b1;
        break;
      end
    end
    check("in_accept", int'(accepted), 1);
    if (accepted && track && r >= 2 && c >= 2) sb_q.push_back(model(r - 1, c - 1));
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    sof_i      = 1'b0;
  endtask

  // Sends raster pixels from (0,0) up to, but excluding, (stop_r, stop_c).
  task automatic send_frame(input int stop_r, input int stop_c);
    align();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (rand_gap && $urandom_range(0, 3) == 0) align();
        send_pixel(r, c, (r == 0 && c == 0), 1'b1);
      end
    end
  endtask

  task automatic wait_drain(input string tag, input bit need_idle);
    bit done = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid_o && (!need_idle || !busy_o)) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, int'(done), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input string tag);
    out_count = 0;
    fd_count  = 0;
    send_frame(H, 0);
    wait_drain({tag, "_drain"}, 1'b1);
    check({tag, "_count"}, out_count, NOUT);
    check({tag, "_frame_done"}, fd_count, 1);
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 255);
  endtask

  initial begin
    reset_i    = 1'b1;
    sof_i      = 1'b0;
    in_valid_i = 1'b0;
    in_pixel_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid_o), 0);
    check("rst_out_pixel", int'(out_pixel_o), 0);
    check("rst_frame_done", int'(frame_done_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_in_ready", int'(in_ready_o), 1);
    check("rst_state", int'(dut.state_q), int'(IDLE));
    reset_i = 1'b0;

    // Pixels without sof in IDLE are dropped.
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 50;
    align();
    for (int i = 0; i < 3; i++) send_pixel(0, i, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("idle_drop_busy", int'(busy_o), 0);
    check("idle_drop_valid", int'(out_valid_o), 0);

    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 100;
    run_frame("uniform");

    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = c;
    run_frame("ramp");

    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < W / 2) ? 0 : 200;
    run_frame("step");

    rand_ready = 1'b1;
    rand_gap   = 1'b1;
    fill_random();
    run_frame("random_bp");
    rand_ready = 1'b0;
    rand_gap   = 1'b0;

    // Abort: sof replaces pixel (3,4) of the first frame.
    fd_count = 0;
    fill_random();
    send_frame(3, 4);
    wait_drain("abort_partial_drain", 1'b0);
    check("abort_busy_mid", int'(busy_o), 1);
    fill_random();
    out_count = 0;
    send_frame(H, 0);
    wait_drain("abort_second_drain", 1'b1);
    check("abort_count", out_count, NOUT);
    check("abort_frame_done", fd_count, 1);

    // Reset while a result is stalled in the output register.
    fill_random();
    hold_ready = 1'b1;
    align();
    align();
    send_frame(2, 3);
    @(negedge clk);
    check("rstrun_pre_valid", int'(out_valid_o), 1);
    reset_i = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("rstrun_out_valid", int'(out_valid_o), 0);
    check("rstrun_busy", int'(busy_o), 0);
    check("rstrun_in_ready", int'(in_ready_o), 1);
    check("rstrun_state", int'(dut.state_q), int'(IDLE));
    reset_i    = 1'b0;
    hold_ready = 1'b0;
    align();
    fill_random();
    run_frame("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
